// File: rtl/mips_register_file.sv
// mips_register_file
//   Integer register file for the MIPS datapath. Holds 2**ADDR_WIDTH entries of
//   DATA_WIDTH bits. Entry 0 is hardwired to zero and has no storage.
//   It provides two combinational read ports with optional write-through bypass.
//   A third combinational debug port returns the stored value only and never
//   forwards a pending write.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all entries and forces reads to 0
//   RegWrite       write enable from write-back
//   WriteRegister  destination index (RegDst mux output)
//   WriteData      value to write
//   ReadRegister1  read port 1 index (rs)
//   ReadRegister2  read port 2 index (rt)
//   ReadData1      read port 1 data
//   ReadData2      read port 2 data
//   DebugAddr      debug read index
//   DebugData      debug read data, stored value only

module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] DebugAddr,
    output logic [DATA_WIDTH-1:0] DebugData
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    // Index 0 is excluded from storage entirely.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    // The && short-circuits on RegWrite=0, so an X index or X data cannot
    // reach the storage or the bypass path while writes are disabled.
    logic write_en;
    logic bypass_hit1;
    logic bypass_hit2;

    assign write_en    = RegWrite && (WriteRegister != '0);
    assign bypass_hit1 = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister1);
    assign bypass_hit2 = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (write_en && (WriteRegister == ADDR_WIDTH'(i))) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Decoded lookup. This avoids indexing the 1-based array with 0.
    function automatic logic [DATA_WIDTH-1:0] stored_value(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                value = regs[i];
            end
        end
        return value;
    endfunction

    // Precedence on each read port is: reset, then index 0, then bypass, then the stored entry.
    always_comb begin
        ReadData1 = '0;
        if (!reset && (ReadRegister1 != '0)) begin
            ReadData1 = bypass_hit1 ? WriteData : stored_value(ReadRegister1);
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!reset && (ReadRegister2 != '0)) begin
            ReadData2 = bypass_hit2 ? WriteData : stored_value(ReadRegister2);
        end
    end

    always_comb begin
        DebugData = '0;
        if (!reset) begin
            DebugData = stored_value(DebugAddr);
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file
//   Directed bench for mips_register_file. It runs one forwarding instance and
//   one non-forwarding instance (BYPASS=0) from shared stimulus.
//   Expected values are hand-computed constants.

module tb_mips_register_file;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  DebugAddr;
    logic [31:0] ReadData1, ReadData2, DebugData;
    logic [31:0] nb_ReadData1, nb_ReadData2, nb_DebugData;

    int checks = 0;
    int passed = 0;

    mips_register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .BYPASS(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .DebugAddr(DebugAddr),
        .DebugData(DebugData)
    );

    mips_register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .BYPASS(0)
    ) dut_nobypass (
        .clk(clk),
        .reset(reset),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1(nb_ReadData1),
        .ReadData2(nb_ReadData2),
        .DebugAddr(DebugAddr),
        .DebugData(nb_DebugData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Writes occur at a posedge. Inputs are released 1 time unit after the edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        RegWrite      = 1'b1;
        WriteRegister = addr;
        WriteData     = data;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        DebugAddr     = '0;

        // 1: reads are zero while reset is held and after it is released.
        #2;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            DebugAddr     = 5'(i);
            #1;
            check($sformatf("rst_rd1[%0d]", i), ReadData1, 32'h0);
            check($sformatf("rst_rd2[%0d]", 31 - i), ReadData2, 32'h0);
            check($sformatf("rst_dbg[%0d]", i), DebugData, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            #1;
            check($sformatf("post_rst_rd1[%0d]", i), ReadData1, 32'h0);
            check($sformatf("post_rst_rd2[%0d]", i), ReadData2, 32'h0);
        end

        // 2: basic write then read.
        @(negedge clk);
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        do_write(5'd8, 32'hDEADBEEF);
        do_write(5'd31, 32'h00000001);
        ReadRegister1 = 5'd8;
        ReadRegister2 = 5'd31;
        DebugAddr     = 5'd8;
        #1;
        check("wr_rd1_r8", ReadData1, 32'hDEADBEEF);
        check("wr_rd2_r31", ReadData2, 32'h00000001);
        check("wr_dbg_r8", DebugData, 32'hDEADBEEF);
        check("wr_nb_rd1_r8", nb_ReadData1, 32'hDEADBEEF);

        // 3: writes to the zero register are discarded.
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd0;
        WriteData     = 32'hFFFFFFFF;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        DebugAddr     = 5'd0;
        #1;
        check("zero_pre_rd1", ReadData1, 32'h0);
        check("zero_pre_rd2", ReadData2, 32'h0);
        check("zero_pre_dbg", DebugData, 32'h0);
        @(posedge clk);
        #1;
        check("zero_post_rd1", ReadData1, 32'h0);
        check("zero_post_dbg", DebugData, 32'h0);
        RegWrite = 1'b0;

        // 4: same-cycle bypass on both ports. The debug port sees the stored value.
        @(negedge clk);
        do_write(5'd5, 32'h11111111);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 32'h22222222;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd5;
        DebugAddr     = 5'd5;
        #1;
        check("byp_pre_rd1", ReadData1, 32'h22222222);
        check("byp_pre_rd2", ReadData2, 32'h22222222);
        check("byp_pre_dbg", DebugData, 32'h11111111);
        check("nobyp_pre_rd1", nb_ReadData1, 32'h11111111);
        check("nobyp_pre_rd2", nb_ReadData2, 32'h11111111);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        #1;
        check("byp_post_rd1", ReadData1, 32'h22222222);
        check("byp_post_rd2", ReadData2, 32'h22222222);
        check("byp_post_dbg", DebugData, 32'h22222222);
        check("nobyp_post_rd1", nb_ReadData1, 32'h22222222);

        // 5: write disabled. Nothing is stored and nothing is forwarded.
        @(negedge clk);
        RegWrite      = 1'b0;
        WriteRegister = 5'd9;
        WriteData     = 32'hA5A5A5A5;
        ReadRegister1 = 5'd9;
        ReadRegister2 = 5'd9;
        DebugAddr     = 5'd9;
        for (int e = 0; e < 3; e++) begin
            #1;
            check($sformatf("wdis_rd1[%0d]", e), ReadData1, 32'h0);
            check($sformatf("wdis_rd2[%0d]", e), ReadData2, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("wdis_dbg[%0d]", e), DebugData, 32'h0);
        end

        // 5b: with writes disabled, X on the write index and data must not leak.
        WriteRegister = 'x;
        WriteData     = 'x;
        ReadRegister1 = 5'd8;
        ReadRegister2 = 5'd5;
        DebugAddr     = 5'd31;
        #1;
        check("x_pre_rd1", ReadData1, 32'hDEADBEEF);
        check("x_pre_rd2", ReadData2, 32'h22222222);
        @(posedge clk);
        #1;
        check("x_post_rd1", ReadData1, 32'hDEADBEEF);
        check("x_post_rd2", ReadData2, 32'h22222222);
        check("x_post_dbg", DebugData, 32'h00000001);

        // 6: fill r1..r31, pulse reset between edges, then write after release.
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i));
        end
        ReadRegister1 = 5'd17;
        ReadRegister2 = 5'd31;
        DebugAddr     = 5'd1;
        #1;
        check("fill_rd1_r17", ReadData1, 32'd17);
        check("fill_rd2_r31", ReadData2, 32'd31);
        check("fill_dbg_r1", DebugData, 32'd1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_rd1", ReadData1, 32'h0);
        check("mid_rst_rd2", ReadData2, 32'h0);
        check("mid_rst_dbg", DebugData, 32'h0);
        // Forwarding is suppressed while reset is high.
        RegWrite      = 1'b1;
        WriteRegister = 5'd4;
        WriteData     = 32'hCAFEF00D;
        ReadRegister1 = 5'd4;
        ReadRegister2 = 5'd4;
        #1;
        check("mid_rst_byp_rd1", ReadData1, 32'h0);
        check("mid_rst_byp_rd2", ReadData2, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        RegWrite      = 1'b0;
        ReadRegister2 = 5'd31;
        DebugAddr     = 5'd4;
        #1;
        check("rel_wr_rd1_r4", ReadData1, 32'hCAFEF00D);
        check("rel_wr_dbg_r4", DebugData, 32'hCAFEF00D);
        check("rel_cleared_r31", ReadData2, 32'h0);
        ReadRegister1 = 5'd17;
        #1;
        check("rel_cleared_r17", ReadData1, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
